clut_loader: RTL
================

# clut_loader

Streams palette entries into the write port of the colour lookup table. A host or ROM reader supplies colours on a valid/ready stream. The block writes them to consecutive CLUT indices starting at a programmed base, wrapping modulo table depth. It sits between the palette source and the CLUT write side, on the same clock as the CLUT write port.

## Interface
- COLRW, 12, colour width (bits)
- CIDXW, 4, colour index width (bits); table depth 2**CIDXW
- clk  in  1  clock; CLUT write clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to begin a load; honoured only in IDLE
- base  in  CIDXW  first index to write; sampled on accepted start
- count  in  CIDXW+1  entries to write; sampled on accepted start; 0 means 2**CIDXW
- vblank  in  1  write-permit window (used only with gating compiled in)
- s_valid  in  1  colour beat valid
- s_ready  out  1  colour beat accepted when s_valid && s_ready
- s_colr  in  COLRW  colour beat data
- we  out  1  CLUT write enable
- cidx_write  out  CIDXW  CLUT write index
- colr_out  out  COLRW  CLUT write colour
- busy  out  1  high from the cycle after accepted start through the done cycle
- done  out  1  one-cycle pulse coincident with the final write

## Operation
- States: IDLE, LOAD, FLUSH.
- IDLE: s_ready=0. On start, latch base into idx and count into remaining. count=0 is stored as 2**CIDXW. Go to LOAD.
- LOAD: s_ready=1, gated as in Configuration. On each handshake, register s_colr and idx for write, then idx<=idx+1 (mod 2**CIDXW) and remaining<=remaining-1.
- On the handshake where remaining==1, go to FLUSH.
- FLUSH: the final registered write issues. done=1 and s_ready=0. Next state is IDLE.
- start while not IDLE: ignored; no effect on idx, remaining or outputs.
- s_valid while IDLE or FLUSH: not accepted. Data is held by the source.
- Wrap-around: base=2**CIDXW-1 with count=2 writes indices 2**CIDXW-1 then 0.
- Reset mid-load: all state clears immediately to IDLE. Any partially loaded palette remains in the CLUT as written. No further writes occur.
- remaining width is CIDXW+1 and is unsigned. It never underflows because LOAD exits at remaining==1.

## Timing
- Reset values: s_ready=0, we=0, cidx_write=0, colr_out=0, busy=0, done=0. State is IDLE.
- Outputs are registered except s_ready, which is a combinational decode of state and the gate.
- Write latency: a handshake in cycle N produces we=1 in cycle N+1 with that beat's index and colour.
- Back-to-back: a beat every cycle gives a write every cycle. Throughput is one entry per clock.
- start in cycle N: busy=1 and s_ready may assert from cycle N+1. The earliest first write is in cycle N+2.
- done coincides with the cycle carrying we for the last entry. busy drops the following cycle. A new start is accepted in that same following cycle (state IDLE).
- we=0 in every cycle not following a handshake. cidx_write and colr_out hold their last values.

## Configuration
- Macro: CLUT_LOADER_VBLANK_EN.
- Defined: s_ready = (state==LOAD) && vblank. A beat is never accepted outside vblank. A load stalls across active video and resumes at the next vblank.
  - vblank falling in the same cycle as a presented beat: that beat is not accepted.
  - A handshake accepted in the last vblank cycle still writes in the next cycle.
- Undefined: vblank is ignored and s_ready = (state==LOAD).

## Structure
- Shared package clut_pkg holds:
  - default COLRW/CIDXW constants;
  - the loader state enum (IDLE, LOAD, FLUSH), shared with future palette blocks.
- No sub-module. The block is a single FSM with the idx/remaining counters.
- The top level instantiates it alongside the CLUT, wiring we, cidx_write and colr_out to the CLUT write port.

## Test plan
- Reset, then start base=0 count=4 with s_valid held high and colours 0x111,0x222,0x333,0x444 -> writes at idx 0..3 on four consecutive cycles starting 2 cycles after start; done with the 0x444 write; busy low the cycle after.
- start base=15 count=3 (CIDXW=4) -> writes idx 15,0,1.
- count=0 -> exactly 16 writes, idx base..base+15 mod 16, one done pulse.
- s_valid toggling 1,0,1,0 -> we follows with one-cycle lag; no write on idle cycles; index advances only on handshakes.
- start asserted mid-load, then rst_n pulled low mid-load -> the mid-load start is ignored; rst_n low forces we/busy/s_ready to 0 immediately; a subsequent start works from IDLE.
- With CLUT_LOADER_VBLANK_EN: vblank=0 for 20 cycles with s_valid=1 -> s_ready=0 and no writes; vblank rises -> writes resume from the unconsumed beat.

Source files
------------

// File: rtl/clut_pkg.sv
// Shared palette definitions: default colour/index widths and the loader state enum.
package clut_pkg;

  localparam int CLUT_COLRW = 12;
  localparam int CLUT_CIDXW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } load_state_t;

endpackage

// File: rtl/clut_loader.sv
// Streams palette colours into consecutive CLUT indices from a programmed base, modulo depth.
// Optional CLUT_LOADER_VBLANK_EN restricts beat acceptance to the vblank window.
module clut_loader
  import clut_pkg::*;
#(
  parameter int COLRW = CLUT_COLRW,
  parameter int CIDXW = CLUT_CIDXW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CIDXW-1:0] base,
  input  logic [CIDXW:0]   count,
  input  logic             vblank,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [COLRW-1:0] s_colr,
  output logic             we,
  output logic [CIDXW-1:0] cidx_write,
  output logic [COLRW-1:0] colr_out,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for start, stream not accepted
  // LOAD  | accepting beats, one write per handshake
  // FLUSH | final write on the CLUT port, done pulse
  load_state_t      state;
  logic [CIDXW-1:0] idx;
  logic [CIDXW:0]   remaining;
  logic             gate;
  logic             handshake;

`ifdef CLUT_LOADER_VBLANK_EN
  assign gate = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign gate          = 1'b1;
`endif

  assign s_ready   = (state == LOAD) && gate;
  assign handshake = s_ready && s_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      remaining  <= '0;
      we         <= 1'b0;
      cidx_write <= '0;
      colr_out   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx <= base;
            // count of zero means a full table
            remaining <= (count == '0) ? {1'b1, {CIDXW{1'b0}}} : count;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (handshake) begin
            we         <= 1'b1;
            cidx_write <= idx;
            colr_out   <= s_colr;
            idx        <= idx + 1'b1;
            remaining  <= remaining - 1'b1;
            if (remaining == {{CIDXW{1'b0}}, 1'b1}) begin
              done  <= 1'b1;
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
